// File: rtl/rv32_pipe_core.sv
// rv32_pipe_core: five-stage in-order RV32 integer core (IF, ID, EX, MEM, WB).
// The core has its own instruction memory, data memory and 32x32 register file.
// Branches (beq) are resolved in ID with a one-slot IF/ID flush. A load-use
// hazard inserts one bubble. EX operands are forwarded from EX/MEM and MEM/WB.
//
// Ports:
//   clk_i    single clock, all state updates on the rising edge
//   rst_i    synchronous, active-low reset (PC and pipeline registers only)
//   start_i  run enable; when low, the whole core holds its state
module rv32_pipe_core #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 32
) (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    localparam int IMEM_AW = $clog2(IMEM_WORDS);
    localparam int DMEM_AW = $clog2(DMEM_WORDS);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_XOR = 3'd3;
    localparam logic [2:0] ALU_SLL = 3'd4;
    localparam logic [2:0] ALU_MUL = 3'd5;
    localparam logic [2:0] ALU_SRA = 3'd6;

    // Storage arrays; not touched by reset.
    logic [31:0] imem [IMEM_WORDS];
    logic [31:0] dmem [DMEM_WORDS];
    logic [31:0] rf   [32];

    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_instr_q;
    logic [31:0] idex_rs1_val_q, idex_rs2_val_q, idex_imm_q;
    logic [4:0]  idex_rs1_q, idex_rs2_q, idex_rd_q;
    logic [2:0]  idex_alu_op_q;
    logic        idex_alu_src_q, idex_reg_write_q, idex_mem_read_q;
    logic        idex_mem_write_q, idex_mem_to_reg_q;
    logic [31:0] exmem_alu_q, exmem_store_q;
    logic [4:0]  exmem_rd_q;
    logic        exmem_reg_write_q, exmem_mem_write_q, exmem_mem_to_reg_q;
    logic [31:0] memwb_alu_q, memwb_load_q;
    logic [4:0]  memwb_rd_q;
    logic        memwb_reg_write_q, memwb_mem_to_reg_q;

    function automatic logic [31:0] alu_f(input logic [2:0] op,
                                          input logic signed [31:0] a,
                                          input logic signed [31:0] b);
        case (op)
            ALU_SUB: alu_f = a - b;
            ALU_AND: alu_f = a & b;
            ALU_XOR: alu_f = a ^ b;
            ALU_SLL: alu_f = a << b[4:0];
            ALU_MUL: alu_f = a * b;          // low 32 bits of the product
            ALU_SRA: alu_f = a >>> b[4:0];
            default: alu_f = a + b;
        endcase
    endfunction

    // ---------------- ID stage ----------------
    logic [6:0]  id_opcode, id_f7;
    logic [2:0]  id_f3;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [31:0] id_imm_i, id_imm_s, id_imm_b, id_imm;
    logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
    logic        id_alu_src, id_is_beq;
    logic [2:0]  id_alu_op;
    logic [31:0] wb_data, id_rs1_val, id_rs2_val, branch_target;
    logic        wb_en, stall, flush;

    assign id_opcode = ifid_instr_q[6:0];
    assign id_rd     = ifid_instr_q[11:7];
    assign id_f3     = ifid_instr_q[14:12];
    assign id_rs1    = ifid_instr_q[19:15];
    assign id_rs2    = ifid_instr_q[24:20];
    assign id_f7     = ifid_instr_q[31:25];
    assign id_imm_i  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:20]};
    assign id_imm_s  = {{20{ifid_instr_q[31]}}, ifid_instr_q[31:25], ifid_instr_q[11:7]};
    assign id_imm_b  = {{19{ifid_instr_q[31]}}, ifid_instr_q[31], ifid_instr_q[7],
                        ifid_instr_q[30:25], ifid_instr_q[11:8], 1'b0};

    // Unrecognised encodings fall through with all controls low (NOP).
    always_comb begin
        id_reg_write  = 1'b0;
        id_mem_read   = 1'b0;
        id_mem_write  = 1'b0;
        id_mem_to_reg = 1'b0;
        id_alu_src    = 1'b0;
        id_is_beq     = 1'b0;
        id_alu_op     = ALU_ADD;
        id_imm        = id_imm_i;
        case (id_opcode)
            OP_R: begin
                id_reg_write = 1'b1;
                case ({id_f7, id_f3})
                    {7'b0000000, 3'b111}: id_alu_op = ALU_AND;
                    {7'b0000000, 3'b100}: id_alu_op = ALU_XOR;
                    {7'b0000000, 3'b001}: id_alu_op = ALU_SLL;
                    {7'b0000000, 3'b000}: id_alu_op = ALU_ADD;
                    {7'b0100000, 3'b000}: id_alu_op = ALU_SUB;
                    {7'b0000001, 3'b000}: id_alu_op = ALU_MUL;
                    default:              id_reg_write = 1'b0;
                endcase
            end
            OP_IMM: begin
                if (id_f3 == 3'b000) begin
                    id_reg_write = 1'b1;
                    id_alu_src   = 1'b1;
                end else if (id_f3 == 3'b101 && id_f7 == 7'b0100000) begin
                    id_reg_write = 1'b1;
                    id_alu_src   = 1'b1;
                    id_alu_op    = ALU_SRA;
                end
            end
            OP_LOAD: begin
                if (id_f3 == 3'b010) begin
                    id_reg_write  = 1'b1;
                    id_mem_read   = 1'b1;
                    id_mem_to_reg = 1'b1;
                    id_alu_src    = 1'b1;
                end
            end
            OP_STORE: begin
                if (id_f3 == 3'b010) begin
                    id_mem_write = 1'b1;
                    id_alu_src   = 1'b1;
                    id_imm       = id_imm_s;
                end
            end
            OP_BRANCH: id_is_beq = (id_f3 == 3'b000);
            default: ;
        endcase
    end

    // Register read with write-through from the instruction retiring in WB.
    assign wb_data    = memwb_mem_to_reg_q ? memwb_load_q : memwb_alu_q;
    assign wb_en      = memwb_reg_write_q && (memwb_rd_q != 5'd0);
    assign id_rs1_val = (id_rs1 == 5'd0) ? 32'd0 :
                        (wb_en && memwb_rd_q == id_rs1) ? wb_data : rf[id_rs1];
    assign id_rs2_val = (id_rs2 == 5'd0) ? 32'd0 :
                        (wb_en && memwb_rd_q == id_rs2) ? wb_data : rf[id_rs2];

    // Raw rs1/rs2 fields are compared regardless of format.
    assign stall = idex_mem_read_q && (idex_rd_q != 5'd0) &&
                   ((idex_rd_q == id_rs1) || (idex_rd_q == id_rs2));
    // A stall wins over a taken branch; the branch re-evaluates next cycle.
    assign flush = id_is_beq && (id_rs1_val == id_rs2_val) && !stall;
    assign branch_target = ifid_pc_q + id_imm_b;
    assign pc_d = stall ? pc_q : (flush ? branch_target : pc_q + 32'd4);

    // ---------------- EX stage ----------------
    logic [31:0] ex_fwd_a, ex_fwd_b, ex_alu_b, ex_result;

    assign ex_fwd_a = (exmem_reg_write_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs1_q) ? exmem_alu_q :
                      (wb_en && memwb_rd_q == idex_rs1_q) ? wb_data : idex_rs1_val_q;
    assign ex_fwd_b = (exmem_reg_write_q && exmem_rd_q != 5'd0 && exmem_rd_q == idex_rs2_q) ? exmem_alu_q :
                      (wb_en && memwb_rd_q == idex_rs2_q) ? wb_data : idex_rs2_val_q;
    assign ex_alu_b  = idex_alu_src_q ? idex_imm_q : ex_fwd_b;
    assign ex_result = alu_f(idex_alu_op_q, ex_fwd_a, ex_alu_b);

    // ---------------- MEM stage ----------------
    logic [31:0] mem_rdata;
    assign mem_rdata = dmem[exmem_alu_q[DMEM_AW+1:2]];

    always_ff @(posedge clk_i) begin
        if (rst_i && start_i && exmem_mem_write_q)
            dmem[exmem_alu_q[DMEM_AW+1:2]] <= exmem_store_q;
    end

    // ---------------- WB stage ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i && start_i && wb_en)
            rf[memwb_rd_q] <= wb_data;
    end

    // ---------------- pipeline registers ----------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q <= '0;
            ifid_pc_q <= '0;       ifid_instr_q <= '0;
            idex_rs1_val_q <= '0;  idex_rs2_val_q <= '0;  idex_imm_q <= '0;
            idex_rs1_q <= '0;      idex_rs2_q <= '0;      idex_rd_q <= '0;
            idex_alu_op_q <= '0;   idex_alu_src_q <= 1'b0;
            idex_reg_write_q <= 1'b0; idex_mem_read_q <= 1'b0;
            idex_mem_write_q <= 1'b0; idex_mem_to_reg_q <= 1'b0;
            exmem_alu_q <= '0;     exmem_store_q <= '0;   exmem_rd_q <= '0;
            exmem_reg_write_q <= 1'b0; exmem_mem_write_q <= 1'b0; exmem_mem_to_reg_q <= 1'b0;
            memwb_alu_q <= '0;     memwb_load_q <= '0;    memwb_rd_q <= '0;
            memwb_reg_write_q <= 1'b0; memwb_mem_to_reg_q <= 1'b0;
        end else if (start_i) begin
            pc_q <= pc_d;
            // IF -> ID: hold on stall, squash the wrong-path fetch on a taken branch
            if (!stall) begin
                ifid_pc_q    <= flush ? 32'd0 : pc_q;
                ifid_instr_q <= flush ? 32'd0 : imem[pc_q[IMEM_AW+1:2]];
            end
            // ID -> EX: a stall sends a bubble with all control low
            idex_rs1_val_q    <= id_rs1_val;
            idex_rs2_val_q    <= id_rs2_val;
            idex_imm_q        <= id_imm;
            idex_rs1_q        <= id_rs1;
            idex_rs2_q        <= id_rs2;
            idex_rd_q         <= stall ? 5'd0 : id_rd;
            idex_alu_op_q     <= stall ? ALU_ADD : id_alu_op;
            idex_alu_src_q    <= !stall && id_alu_src;
            idex_reg_write_q  <= !stall && id_reg_write;
            idex_mem_read_q   <= !stall && id_mem_read;
            idex_mem_write_q  <= !stall && id_mem_write;
            idex_mem_to_reg_q <= !stall && id_mem_to_reg;
            // EX -> MEM
            exmem_alu_q        <= ex_result;
            exmem_store_q      <= ex_fwd_b;
            exmem_rd_q         <= idex_rd_q;
            exmem_reg_write_q  <= idex_reg_write_q;
            exmem_mem_write_q  <= idex_mem_write_q;
            exmem_mem_to_reg_q <= idex_mem_to_reg_q;
            // MEM -> WB
            memwb_alu_q        <= exmem_alu_q;
            memwb_load_q       <= mem_rdata;
            memwb_rd_q         <= exmem_rd_q;
            memwb_reg_write_q  <= exmem_reg_write_q;
            memwb_mem_to_reg_q <= exmem_mem_to_reg_q;
        end
    end
endmodule

// File: tb/tb_rv32_pipe_core.sv
// Directed bench for rv32_pipe_core: small programs are loaded into the
// instruction memory while the core is held in reset, then run for a fixed
// number of cycles; register/memory results and stall/flush counts are checked.
module tb_rv32_pipe_core;
    logic clk = 1'b0;
    logic rst_i;
    logic start_i;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_cnt;
    int flush_cnt;

    localparam logic [6:0] OP_IMM = 7'b0010011;

    rv32_pipe_core #(.IMEM_WORDS(256), .DMEM_WORDS(32)) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .start_i(start_i)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {imm, rs1, f3, rd, op};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    // Hold reset for two edges and fill instruction memory with NOPs.
    task automatic hold_reset();
        rst_i   = 1'b0;
        start_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 256; i++) dut.imem[i] <= 32'h0;
    endtask

    task automatic run_cycles(input int n);
        rst_i     = 1'b1;
        stall_cnt = 0;
        flush_cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (dut.stall) stall_cnt++;
            if (dut.flush) flush_cnt++;
        end
    endtask

    task automatic test_reset();
        hold_reset();
        dut.imem[0] <= enc_i(12'd123, 5'd0, 3'b000, 5'd7, OP_IMM);
        dut.imem[1] <= enc_i(12'd55,  5'd0, 3'b000, 5'd8, OP_IMM);
        dut.imem[2] <= enc_i(12'd1,   5'd0, 3'b000, 5'd9, OP_IMM);
        run_cycles(8);
        n_tests++;
        if (dut.rf[7] !== 32'd123) begin
            $display("FAIL reset_setup_x7: got %0d expected 123", dut.rf[7]); n_fail++;
        end
        // Restart so that the pipeline holds live instructions, then reset.
        rst_i = 1'b0;
        @(negedge clk);
        run_cycles(3);
        rst_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (dut.pc_q !== 32'd0) begin
                $display("FAIL reset_pc_edge%0d: got %h expected 00000000", k, dut.pc_q); n_fail++;
            end
        end
        n_tests++;
        if (dut.ifid_instr_q !== 32'd0) begin
            $display("FAIL reset_ifid_instr: got %h expected 00000000", dut.ifid_instr_q); n_fail++;
        end
        n_tests++;
        if (dut.idex_rd_q !== 5'd0 || dut.idex_imm_q !== 32'd0 || dut.idex_reg_write_q !== 1'b0) begin
            $display("FAIL reset_idex: rd=%0d imm=%h we=%b expected 0 0 0",
                     dut.idex_rd_q, dut.idex_imm_q, dut.idex_reg_write_q); n_fail++;
        end
        n_tests++;
        if (dut.exmem_alu_q !== 32'd0 || dut.exmem_rd_q !== 5'd0 || dut.exmem_reg_write_q !== 1'b0) begin
            $display("FAIL reset_exmem: alu=%h rd=%0d we=%b expected 0 0 0",
                     dut.exmem_alu_q, dut.exmem_rd_q, dut.exmem_reg_write_q); n_fail++;
        end
        n_tests++;
        if (dut.memwb_reg_write_q !== 1'b0 || dut.memwb_rd_q !== 5'd0) begin
            $display("FAIL reset_memwb: we=%b rd=%0d expected 0 0",
                     dut.memwb_reg_write_q, dut.memwb_rd_q); n_fail++;
        end
        n_tests++;
        if (dut.rf[7] !== 32'd123) begin
            $display("FAIL reset_rf_kept: got %0d expected 123", dut.rf[7]); n_fail++;
        end
        rst_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (dut.pc_q !== 32'(4 * k)) begin
                $display("FAIL release_pc_cycle%0d: got %0d expected %0d", k, dut.pc_q, 4 * k); n_fail++;
            end
        end
    endtask

    task automatic test_forwarding();
        hold_reset();
        dut.imem[0] <= enc_i(12'd3, 5'd0, 3'b000, 5'd1, OP_IMM);
        dut.imem[1] <= enc_i(12'd4, 5'd1, 3'b000, 5'd2, OP_IMM);
        dut.imem[2] <= enc_r(7'b0000000, 5'd1, 5'd2, 3'b000, 5'd3);
        run_cycles(10);
        n_tests++;
        if (dut.rf[1] !== 32'd3) begin $display("FAIL fwd_x1: got %0d expected 3", dut.rf[1]); n_fail++; end
        n_tests++;
        if (dut.rf[2] !== 32'd7) begin $display("FAIL fwd_x2: got %0d expected 7", dut.rf[2]); n_fail++; end
        n_tests++;
        if (dut.rf[3] !== 32'd10) begin $display("FAIL fwd_x3: got %0d expected 10", dut.rf[3]); n_fail++; end
        n_tests++;
        if (stall_cnt !== 0) begin $display("FAIL fwd_stalls: got %0d expected 0", stall_cnt); n_fail++; end
    endtask

    task automatic test_load_use();
        hold_reset();
        dut.dmem[0] <= 32'd5;
        dut.imem[0] <= enc_i(12'd0, 5'd0, 3'b010, 5'd1, 7'b0000011);
        dut.imem[1] <= enc_r(7'b0000000, 5'd1, 5'd1, 3'b000, 5'd2);
        run_cycles(10);
        n_tests++;
        if (dut.rf[1] !== 32'd5) begin $display("FAIL lu_x1: got %0d expected 5", dut.rf[1]); n_fail++; end
        n_tests++;
        if (dut.rf[2] !== 32'd10) begin $display("FAIL lu_x2: got %0d expected 10", dut.rf[2]); n_fail++; end
        n_tests++;
        if (stall_cnt !== 1) begin $display("FAIL lu_stalls: got %0d expected 1", stall_cnt); n_fail++; end
    endtask

    task automatic test_branch();
        hold_reset();
        dut.imem[0] <= enc_i(12'd0, 5'd0, 3'b000, 5'd5, OP_IMM);   // x5 = 0
        dut.imem[1] <= enc_i(12'd1, 5'd0, 3'b000, 5'd1, OP_IMM);   // x1 = 1
        dut.imem[4] <= enc_b(13'd8, 5'd1, 5'd1);                   // beq x1,x1,+8
        dut.imem[5] <= enc_i(12'd9, 5'd0, 3'b000, 5'd5, OP_IMM);   // skipped
        dut.imem[6] <= enc_i(12'd4, 5'd0, 3'b000, 5'd6, OP_IMM);   // x6 = 4
        run_cycles(14);
        n_tests++;
        if (flush_cnt !== 1) begin $display("FAIL br_flushes: got %0d expected 1", flush_cnt); n_fail++; end
        n_tests++;
        if (dut.rf[5] !== 32'd0) begin $display("FAIL br_x5_skipped: got %0d expected 0", dut.rf[5]); n_fail++; end
        n_tests++;
        if (dut.rf[6] !== 32'd4) begin $display("FAIL br_x6: got %0d expected 4", dut.rf[6]); n_fail++; end
        n_tests++;
        if (stall_cnt !== 0) begin $display("FAIL br_stalls: got %0d expected 0", stall_cnt); n_fail++; end
    endtask

    task automatic test_alu_ops();
        hold_reset();
        dut.imem[0] <= enc_i(12'hFF0, 5'd0, 3'b000, 5'd1, OP_IMM);  // x1 = -16
        dut.imem[1] <= enc_i(12'h402, 5'd1, 3'b101, 5'd2, OP_IMM);  // srai x2,x1,2
        dut.imem[2] <= enc_i(12'd6, 5'd0, 3'b000, 5'd3, OP_IMM);
        dut.imem[3] <= enc_i(12'd7, 5'd0, 3'b000, 5'd4, OP_IMM);
        dut.imem[4] <= enc_r(7'b0000001, 5'd4, 5'd3, 3'b000, 5'd10); // mul
        dut.imem[5] <= enc_r(7'b0100000, 5'd4, 5'd3, 3'b000, 5'd11); // sub
        dut.imem[6] <= enc_r(7'b0000000, 5'd4, 5'd3, 3'b100, 5'd12); // xor
        dut.imem[7] <= enc_r(7'b0000000, 5'd4, 5'd3, 3'b111, 5'd13); // and
        dut.imem[8] <= enc_r(7'b0000000, 5'd4, 5'd3, 3'b001, 5'd14); // sll
        run_cycles(16);
        n_tests++;
        if (dut.rf[2] !== 32'hFFFF_FFFC) begin $display("FAIL alu_srai: got %h expected fffffffc", dut.rf[2]); n_fail++; end
        n_tests++;
        if (dut.rf[10] !== 32'd42) begin $display("FAIL alu_mul: got %0d expected 42", dut.rf[10]); n_fail++; end
        n_tests++;
        if (dut.rf[11] !== 32'hFFFF_FFFF) begin $display("FAIL alu_sub: got %h expected ffffffff", dut.rf[11]); n_fail++; end
        n_tests++;
        if (dut.rf[12] !== 32'd1) begin $display("FAIL alu_xor: got %0d expected 1", dut.rf[12]); n_fail++; end
        n_tests++;
        if (dut.rf[13] !== 32'd6) begin $display("FAIL alu_and: got %0d expected 6", dut.rf[13]); n_fail++; end
        n_tests++;
        if (dut.rf[14] !== 32'd768) begin $display("FAIL alu_sll: got %0d expected 768", dut.rf[14]); n_fail++; end
    endtask

    task automatic test_store_load();
        hold_reset();
        dut.imem[0] <= enc_i(12'd77, 5'd0, 3'b000, 5'd1, OP_IMM);   // x1 = 77
        dut.imem[1] <= enc_s(12'd8, 5'd1, 5'd0);                    // sw x1,8(x0)
        dut.imem[2] <= enc_i(12'd8, 5'd0, 3'b010, 5'd2, 7'b0000011); // lw x2,8(x0)
        dut.imem[3] <= enc_i(12'd5, 5'd0, 3'b000, 5'd0, OP_IMM);    // addi x0,x0,5
        dut.imem[4] <= enc_r(7'b0000000, 5'd0, 5'd0, 3'b000, 5'd3); // add x3,x0,x0
        run_cycles(12);
        n_tests++;
        if (dut.dmem[2] !== 32'd77) begin $display("FAIL sl_dmem2: got %0d expected 77", dut.dmem[2]); n_fail++; end
        n_tests++;
        if (dut.rf[2] !== 32'd77) begin $display("FAIL sl_x2: got %0d expected 77", dut.rf[2]); n_fail++; end
        n_tests++;
        if (dut.rf[0] !== 32'd0) begin $display("FAIL sl_x0_store: got %0d expected 0", dut.rf[0]); n_fail++; end
        n_tests++;
        if (dut.rf[3] !== 32'd0) begin $display("FAIL sl_x0_read: got %0d expected 0", dut.rf[3]); n_fail++; end
    endtask

    initial begin
        rst_i   = 1'b0;
        start_i = 1'b1;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_alu_ops();
        test_store_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
